// File: rtl/aes_cbc_ctrl.sv
//------------------------------------------------------------------------------
// Module : aes_cbc_ctrl
// Brief  : CBC-mode sequencer wrapping an external single-block AES core.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_cbc_ctrl #(
  parameter int CORE_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [127:0]     iv,
  input  logic [127:0]     key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out,
  output logic [127:0]     core_in,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_out,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int               LAT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [127:0]     chain_r;
  logic [127:0]     key_r;
  logic [127:0]     data_r;
  logic [127:0]     out_r;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             lat_done;

  assign out      = out_r;
  assign core_in  = data_r;
  assign core_key = key_r;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lat_done  = (lat_cnt == '0);

    case (state)
      READY: in_ready = 1'b1;
      RUN:   busy = 1'b1;
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase

    // init wins over any handshake in the same cycle
    if (init) in_ready = 1'b0;
    accept = in_valid && in_ready;

    case (state)
      READY: if (accept) state_nxt = RUN;
      RUN:   if (lat_done) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = accept ? RUN : READY;
      default: ;
    endcase

    if (init) state_nxt = READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      chain_r <= '0;
      key_r   <= '0;
      data_r  <= '0;
      out_r   <= '0;
      lat_cnt <= '0;
      blk_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (init) begin
        chain_r <= iv;
        key_r   <= key;
        blk_cnt <= '0;
      end else if (accept) begin
        data_r  <= in ^ chain_r;
        lat_cnt <= LAT_LOAD;
      end else if (state == RUN) begin
        if (!lat_done) begin
          lat_cnt <= lat_cnt - 1'b1;
        end else begin
          // ciphertext doubles as the next chaining value
          out_r   <= core_out;
          chain_r <= core_out;
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes_cbc_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_aes_cbc_ctrl
// Brief  : Self-checking bench for aes_cbc_ctrl with CORE_LAT=1 and CORE_LAT=3.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_cbc_ctrl;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1    = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2    = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PF    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CF    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         init_s      [2];
  logic [127:0] iv_s        [2];
  logic [127:0] key_s       [2];
  logic         in_valid_s  [2];
  logic         in_ready_s  [2];
  logic [127:0] in_s        [2];
  logic         out_valid_s [2];
  logic         out_ready_s [2];
  logic [127:0] out_s       [2];
  logic [127:0] core_in_s   [2];
  logic [127:0] core_key_s  [2];
  logic         busy_s      [2];
  logic [31:0]  blk_cnt_s   [2];

  logic [7:0]   sb [256];
  logic         sb_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [127:0] cout;
    always @(core_in_s[g] or core_key_s[g] or sb_ready)
      cout = aes_enc(core_in_s[g], core_key_s[g]);

    aes_cbc_ctrl #(.CORE_LAT((g == 0) ? 1 : 3), .CNT_W(32)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .init     (init_s[g]),
      .iv       (iv_s[g]),
      .key      (key_s[g]),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .in       (in_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .out      (out_s[g]),
      .core_in  (core_in_s[g]),
      .core_key (core_key_s[g]),
      .core_out (cout),
      .busy     (busy_s[g]),
      .blk_cnt  (blk_cnt_s[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]  st [16];
    logic [7:0]  t  [16];
    logic [31:0] w  [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) st[rr+4*c] = t[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
    return ct;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- transaction-level monitor ----------------
  bit           loaded   [2] = '{0, 0};
  bit           inflight [2] = '{0, 0};
  bit           prev_ov  [2] = '{0, 0};
  int unsigned  mcnt     [2] = '{0, 0};
  int           acc_cyc  [2] = '{0, 0};
  logic [127:0] mkey     [2] = '{'0, '0};
  logic [127:0] mchain   [2] = '{'0, '0};
  logic [127:0] mexp     [2] = '{'0, '0};
  logic [127:0] held     [2] = '{'0, '0};
  int           ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 2; d++) begin
      if (!loaded[d]) begin
        check("idle_in_ready", in_ready_s[d], 0);
        check("idle_out_valid", out_valid_s[d], 0);
      end else begin
        check("core_key", core_key_s[d], mkey[d]);
      end
      check("busy", busy_s[d], inflight[d]);
      if (out_valid_s[d] && !prev_ov[d]) begin
        check("ov_expected", inflight[d], 1);
        check("ov_latency", ncyc - acc_cyc[d], lat_of(d) + 1);
        check("cipher", out_s[d], mexp[d]);
        held[d] = out_s[d];
        mcnt[d]++;
      end else if (out_valid_s[d]) begin
        check("out_stable", out_s[d], held[d]);
      end
      check("blk_cnt", blk_cnt_s[d], mcnt[d]);
      if (init_s[d])
        check("init_in_ready", in_ready_s[d], 0);
      else if (loaded[d]) begin
        if (out_valid_s[d]) check("hold_in_ready", in_ready_s[d], out_ready_s[d]);
        else                check("in_ready", in_ready_s[d], !inflight[d]);
      end
      prev_ov[d] = out_valid_s[d];

      if (rst) begin
        loaded[d] = 0; inflight[d] = 0; mcnt[d] = 0;
        mkey[d] = '0; mchain[d] = '0;
      end else if (init_s[d]) begin
        loaded[d] = 1; inflight[d] = 0; mcnt[d] = 0;
        mkey[d] = key_s[d]; mchain[d] = iv_s[d];
      end else begin
        if (out_valid_s[d] && out_ready_s[d]) inflight[d] = 0;
        if (in_valid_s[d] && in_ready_s[d]) begin
          inflight[d] = 1;
          acc_cyc[d]  = ncyc;
          mexp[d]     = aes_enc(in_s[d] ^ mchain[d], mkey[d]);
          mchain[d]   = mexp[d];
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_init(input int d, input logic [127:0] k, input logic [127:0] v);
    init_s[d] = 1'b1; key_s[d] = k; iv_s[d] = v; in_valid_s[d] = 1'b0;
    @(posedge clk); #1;
    init_s[d] = 1'b0;
  endtask

  task automatic xfer(input int d, input logic [127:0] p1, input logic [127:0] p2,
                      input bit two, input bit bp,
                      output logic [127:0] r1, output logic [127:0] r2,
                      output int t_rise, output int t_b2b);
    int n = 0, n0 = 0, nacc = 0, nout = 0, ovc = 0, need;
    bit acc, ov, ret;
    logic [127:0] hold_v = '0;
    need = two ? 2 : 1;
    r1 = '0; r2 = '0; t_rise = -1; t_b2b = -1;
    in_s[d] = p1; in_valid_s[d] = 1'b1; out_ready_s[d] = !bp;
    while (nout < need && n < 80) begin
      @(negedge clk); n++;
      acc = in_valid_s[d] && in_ready_s[d];
      ov  = out_valid_s[d];
      ret = ov && out_ready_s[d];
      if (ov && t_rise < 0) t_rise = n - n0;
      if (bp && ov && !out_ready_s[d]) begin
        check("bp_in_ready", in_ready_s[d], 0);
        if (ovc == 0) hold_v = out_s[d];
        else          check("bp_out_stable", out_s[d], hold_v);
        ovc++;
      end
      if (acc) begin
        if (nacc == 0) n0 = n;
        nacc++;
      end
      if (ret) begin
        if (nout == 0) r1 = out_s[d];
        else begin r2 = out_s[d]; t_b2b = n - n0; end
        nout++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (two && nacc == 1) in_s[d] = p2;
        else                  in_valid_s[d] = 1'b0;
      end
      if (bp && ovc >= 5) out_ready_s[d] = 1'b1;
    end
    if (nout < need) check("xfer_timeout", nout, need);
    in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
  endtask

  task automatic abort_run(input int d);
    logic [127:0] iv2, r1, r2;
    int tr, tb, n;
    iv2 = rnd128();
    do_init(d, K1, IV1);
    in_s[d] = P1; in_valid_s[d] = 1'b1; out_ready_s[d] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(in_valid_s[d] && in_ready_s[d]) && n < 20);
    check("abort_accept", in_ready_s[d], 1);
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0; init_s[d] = 1'b1; iv_s[d] = iv2; key_s[d] = K1;
    @(posedge clk); #1;
    init_s[d] = 1'b0;
    for (int i = 0; i < 2 * lat_of(d) + 2; i++) begin
      @(negedge clk);
      check("abort_no_out", out_valid_s[d], 0);
      check("abort_blk_cnt", blk_cnt_s[d], 0);
    end
    xfer(d, P1, P1, 0, 0, r1, r2, tr, tb);
    check("abort_new_iv", r1, aes_enc(P1 ^ iv2, K1));
  endtask

  task automatic reset_hold(input int d);
    int n;
    do_init(d, K1, IV1);
    in_s[d] = P1; in_valid_s[d] = 1'b1; out_ready_s[d] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid_s[d] && n < 20);
    check("rst_reach_hold", out_valid_s[d], 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready_s[d], 0);
      check("rst_out_valid", out_valid_s[d], 0);
      check("rst_out", out_s[d], 0);
      check("rst_core_in", core_in_s[d], 0);
      check("rst_core_key", core_key_s[d], 0);
      check("rst_blk_cnt", blk_cnt_s[d], 0);
      check("rst_busy", busy_s[d], 0);
    end
    in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] r1, r2;
    logic [7:0]   inv;
    int           tr, tb;
    bit           took [2];

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
    sb_ready = 1'b1;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      init_s[d] = 1'b0; iv_s[d] = '0; key_s[d] = '0; in_valid_s[d] = 1'b0;
      in_s[d] = '0; out_ready_s[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_out", out_s[d], 0);
      check("reset_core_in", core_in_s[d], 0);
      check("reset_core_key", core_key_s[d], 0);
      check("reset_in_ready", in_ready_s[d], 0);
      check("reset_out_valid", out_valid_s[d], 0);
      check("reset_busy", busy_s[d], 0);
      check("reset_blk_cnt", blk_cnt_s[d], 0);
    end

    for (int d = 0; d < 2; d++) begin
      do_init(d, K1, IV1);
      xfer(d, P1, P1, 0, 0, r1, r2, tr, tb);
      check("kat1_c1", r1, C1);
      check("kat1_latency", tr, lat_of(d) + 1);
      check("kat1_blk_cnt", blk_cnt_s[d], 1);

      do_init(d, K1, IV1);
      xfer(d, P1, P2, 1, 0, r1, r2, tr, tb);
      check("b2b_c1", r1, C1);
      check("b2b_c2", r2, C2);
      check("b2b_cycles", tb, 2 * lat_of(d) + 2);
      check("b2b_blk_cnt", blk_cnt_s[d], 2);

      do_init(d, K1, IV1);
      xfer(d, P1, P2, 1, 1, r1, r2, tr, tb);
      check("bp_c1", r1, C1);
      check("bp_c2", r2, C2);

      do_init(d, K2, '0);
      xfer(d, PF, PF, 0, 0, r1, r2, tr, tb);
      check("fips_c", r1, CF);

      abort_run(d);

      do_init(d, K1, IV1);
      in_s[d] = P1; in_valid_s[d] = 1'b1; init_s[d] = 1'b1;
      @(negedge clk);
      check("init_blocks_accept", in_ready_s[d], 0);
      @(posedge clk); #1;
      init_s[d] = 1'b0;
      xfer(d, P1, P1, 0, 0, r1, r2, tr, tb);
      check("init_then_c1", r1, C1);
      check("init_then_blk_cnt", blk_cnt_s[d], 1);

      reset_hold(d);
    end

    // randomized traffic on both instances, checked by the monitor
    for (int d = 0; d < 2; d++) begin
      init_s[d] = 1'b1; key_s[d] = rnd128(); iv_s[d] = rnd128();
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) init_s[d] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) took[d] = in_valid_s[d] && in_ready_s[d];
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        init_s[d] = 1'b0;
        if ($urandom_range(0, 59) == 0) begin
          init_s[d] = 1'b1; key_s[d] = rnd128(); iv_s[d] = rnd128();
        end
        if (!in_valid_s[d] || took[d]) begin
          in_valid_s[d] = ($urandom_range(0, 9) < 7);
          in_s[d]       = rnd128();
        end
        out_ready_s[d] = ($urandom_range(0, 9) < 6);
      end
    end
    for (int d = 0; d < 2; d++) begin
      init_s[d] = 1'b0; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
